spi_eeprom_responder: RTL and testbench
=======================================

Name: spi_eeprom_responder

Overview:
Synthesizable SPI mode-0 slave that emulates the read path of an M95xxx-style serial EEPROM. It answers the SPI master inside chip_top (spi_clk_out / mosi_out / spi_en_out / miso) on silicon or FPGA builds where no external EEPROM model is present. Byte storage is internal and is preloaded through a parallel load port. It oversamples the SPI pins with the system clock.

Parameters:
DEPTH, 1024, bytes of storage; power of 2, max 65536; address taken modulo DEPTH
SYNC_STAGES, 2, synchronizer flops on spi_clk, mosi and spi_en (minimum 2)
CLK_RATIO_MIN, 8, documented minimum clk/spi_clk ratio; not used in logic, checked by bench assertion

Ports:
clk  input  1  system clock; all logic rises on this edge
reset  input  1  synchronous, active-low reset
spi_clk  input  1  SPI clock from master, idle low (mode 0)
mosi  input  1  serial data from master, MSB first
spi_en  input  1  active-low chip select
miso  output  1  serial data to master; 0 when not driving
miso_oe  output  1  1 while the block drives miso with valid data
load_en  input  1  parallel preload strobe
load_addr  input  $clog2(DEPTH)  preload address
load_data  input  8  preload byte
busy  output  1  1 while spi_en is low (synchronized)

Behaviour:
- Reset (reset==0 at a clk edge): state=IDLE, miso=0, miso_oe=0, busy=0, shift/bit counters=0, address=0. Memory contents are not cleared.
- Input path: SYNC_STAGES-flop synchronizers. Edges are detected from the last two synchronized samples. Rising spi_clk = sample event; falling spi_clk = shift event.
- Sampling: mosi is shifted in MSB first on each sample event. A 3-bit counter marks byte completion.
- FSM states: IDLE, CMD, ADDR_HI, ADDR_LO, DATA_OUT, STATUS_OUT, IGNORE.
- IDLE -> CMD when synchronized spi_en falls. Bit counter is cleared.
- CMD, byte complete:
  - 0x03 -> ADDR_HI
  - 0x05 -> STATUS_OUT
  - any other value -> IGNORE
- ADDR_HI to ADDR_LO: stores the high address byte.
- ADDR_LO, byte complete: address = {hi,lo} mod DEPTH; memory byte fetched into the output shift register within 2 clk; state -> DATA_OUT.
- DATA_OUT:
  - First falling edge after the last address bit drives the MSB; miso_oe=1.
  - Each subsequent falling edge shifts out the next bit.
  - After the 8th bit, the next byte (address+1) is preloaded before the next falling edge.
  - Address wraps from DEPTH-1 to 0. No limit on burst length.
- STATUS_OUT: streams the status byte repeatedly, bit 0 WIP=0, bit 1 WEL (0 without the optional feature), bits 7:2=0.
- IGNORE: miso=0, miso_oe=0 until deselect.
- Deselect: synchronized spi_en rising in any state -> IDLE on the next clk, miso=0, miso_oe=0. A partial byte is discarded and has no side effect.
- Reset mid-transaction: immediate return to IDLE regardless of spi_en. A new transaction needs a fresh spi_en falling edge.
- load_en: writes load_data to load_addr on that clk edge, in any state. If it targets the byte currently being fetched in the same cycle, the fetch returns the new data (write-first).
- busy = inverted synchronized spi_en, forced 0 during reset.

Optional Feature:
Macro SPI_RESP_WRITE_EN.
- Defined:
  - CMD 0x06 (WREN) sets WEL at deselect.
  - CMD 0x04 (WRDI) clears WEL.
  - CMD 0x02 (WRITE) -> ADDR_HI/ADDR_LO, then each complete received byte is written to memory with address auto-increment and the same wrap rule.
  - WRITE with WEL=0: bytes are discarded.
  - WEL clears at deselect after any WRITE.
  - A load_en write in the same cycle as an SPI write to the same address wins.
  - WIP stays 0 (writes are instantaneous).
- Undefined: 0x02, 0x04 and 0x06 go to IGNORE; WEL is constant 0.

Test Plan:
- Reset: hold reset=0 for 3 clk with spi_en toggling -> miso=0, miso_oe=0, busy=0. Preloaded memory is unchanged afterwards.
- Burst read: preload 0x0000..0x0003 = 11,22,33,44; send 03 00 00 with spi_clk=clk/8, then clock 32 bits -> master receives 11 22 33 44; miso_oe=1 only during data bits.
- Wrap: DEPTH=1024, preload 0x3FF=AA and 0x000=55; READ at 0x03FF for 2 bytes -> AA 55. Also READ at address 0x0403 returns byte 0x003.
- Status and unknown command: 05 then 16 clocks -> 00 00. Command 9F -> miso_oe stays 0 and miso=0 through 24 clocks.
- Abort: deselect after 5 address bits, then a full READ at 0x0002 -> correct byte. Reset asserted mid-DATA_OUT -> IDLE, miso_oe=0 on the next clk.
- SPI_RESP_WRITE_EN:
  - Sequence 06 / deselect / 05 -> 02.
  - Then 02 00 10 A5 / deselect; READ 0x0010 -> A5; RDSR -> 00.
  - WRITE without WREN leaves memory unchanged.

Source files
------------

// File: rtl/spi_eeprom_responder.sv
// spi_eeprom_responder: SPI mode-0 slave that emulates the read path of an
// M95xxx-style serial EEPROM, with byte storage held internally and filled
// through a parallel preload port. The SPI pins are oversampled with clk.
// Commands: 0x03 READ (16-bit address, endless burst, wraps at DEPTH) and
// 0x05 RDSR (status byte streamed repeatedly). Any other command is ignored
// until deselect.
// Optional feature macro SPI_RESP_WRITE_EN adds WREN (0x06), WRDI (0x04) and
// WRITE (0x02) with a write-enable latch reported in status bit 1.
module spi_eeprom_responder #(
    parameter int DEPTH         = 1024,
    parameter int SYNC_STAGES   = 2,
    parameter int CLK_RATIO_MIN = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     spi_clk,
    input  logic                     mosi,
    input  logic                     spi_en,
    output logic                     miso,
    output logic                     miso_oe,
    input  logic                     load_en,
    input  logic [$clog2(DEPTH)-1:0] load_addr,
    input  logic [7:0]               load_data,
    output logic                     busy
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [15:0] ADDR_MASK = 16'(DEPTH - 1);

    // The response path needs sync latency + edge detect + output register to
    // fit inside half an SPI clock period; reject configurations that cannot.
    if (SYNC_STAGES < 2 || CLK_RATIO_MIN < 2 * (SYNC_STAGES + 2)) begin : g_param_check
        $error("spi_eeprom_responder: SYNC_STAGES/CLK_RATIO_MIN combination unsupported");
    end

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR_HI, ADDR_LO, DATA_OUT, STATUS_OUT, IGNORE
`ifdef SPI_RESP_WRITE_EN
        , DATA_IN
`endif
    } state_t;

    state_t state, state_next;

    // Synchronized pin samples and the previous synchronized sample of each
    // edge-sensitive pin.
    logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, en_sync;
    logic sclk_prev, en_prev;
    logic sclk_s, mosi_s, en_s;
    logic sclk_rise, sclk_fall, en_rise, en_fall;

    // Datapath state.
    logic [7:0]  mem [DEPTH];
    logic [6:0]  rx_shift;
    logic [7:0]  rx_byte;
    logic [2:0]  bit_cnt;
    logic [2:0]  tx_cnt;
    logic [7:0]  tx_shift;
    logic [7:0]  addr_hi;
    logic [15:0] addr_q;
    logic        fetch_req;
    logic [7:0]  fetch_byte;
    logic [7:0]  status_byte;
    logic        byte_done;
    logic        wel;

    // Control strobes decoded by the FSM.
    logic start, deselect, hi_ld, addr_ld, addr_inc, fetch_set, shift_out;

`ifdef SPI_RESP_WRITE_EN
    logic wren_pend, write_seen;
    logic wren_set, wel_clr, write_cmd, spi_wr;
`else
    assign wel = 1'b0;
`endif

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign en_s      = en_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    assign en_rise   = en_s & ~en_prev;
    assign en_fall   = ~en_s & en_prev;

    assign rx_byte     = {rx_shift, mosi_s};
    assign byte_done   = sclk_rise && (bit_cnt == 3'd7);
    assign status_byte = {6'b0, wel, 1'b0};
    assign busy        = reset & ~en_s;

    // Pin synchronizers. Left out of reset on purpose: after reset the edge
    // detectors see the real pin history, so a transaction that was already
    // selected does not appear as a fresh spi_en falling edge.
    always_ff @(posedge clk) begin
        sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
        mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
        en_sync   <= {en_sync[SYNC_STAGES-2:0], spi_en};
        sclk_prev <= sclk_s;
        en_prev   <= en_s;
    end

    // FSM state register.
    // NOTE: every clocked block uses non-blocking assignments so all registers
    // update from the same pre-edge values, independent of block order.
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // FSM next-state and control-strobe decode.
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        deselect   = 1'b0;
        hi_ld      = 1'b0;
        addr_ld    = 1'b0;
        addr_inc   = 1'b0;
        fetch_set  = 1'b0;
        shift_out  = 1'b0;
`ifdef SPI_RESP_WRITE_EN
        wren_set   = 1'b0;
        wel_clr    = 1'b0;
        write_cmd  = 1'b0;
        spi_wr     = 1'b0;
`endif
        if (en_rise) begin
            // Deselect wins from any state; a partial byte is simply dropped.
            state_next = IDLE;
            deselect   = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (en_fall) begin
                        state_next = CMD;
                        start      = 1'b1;
                    end
                end
                CMD: begin
                    if (byte_done) begin
                        case (rx_byte)
                            8'h03: state_next = ADDR_HI;
                            8'h05: begin
                                state_next = STATUS_OUT;
                                fetch_set  = 1'b1;
                            end
`ifdef SPI_RESP_WRITE_EN
                            8'h02: begin
                                state_next = ADDR_HI;
                                write_cmd  = 1'b1;
                            end
                            8'h06: begin
                                state_next = IGNORE;
                                wren_set   = 1'b1;
                            end
                            8'h04: begin
                                state_next = IGNORE;
                                wel_clr    = 1'b1;
                            end
`endif
                            default: state_next = IGNORE;
                        endcase
                    end
                end
                ADDR_HI: begin
                    if (byte_done) begin
                        state_next = ADDR_LO;
                        hi_ld      = 1'b1;
                    end
                end
                ADDR_LO: begin
                    if (byte_done) begin
                        addr_ld = 1'b1;
`ifdef SPI_RESP_WRITE_EN
                        if (write_seen) begin
                            state_next = DATA_IN;
                        end else begin
                            state_next = DATA_OUT;
                            fetch_set  = 1'b1;
                        end
`else
                        state_next = DATA_OUT;
                        fetch_set  = 1'b1;
`endif
                    end
                end
                DATA_OUT: begin
                    if (sclk_fall) begin
                        shift_out = 1'b1;
                        if (tx_cnt == 3'd7) begin
                            // Last bit of the byte is leaving; prefetch the next one.
                            addr_inc  = 1'b1;
                            fetch_set = 1'b1;
                        end
                    end
                end
                STATUS_OUT: begin
                    if (sclk_fall) begin
                        shift_out = 1'b1;
                        if (tx_cnt == 3'd7) fetch_set = 1'b1;
                    end
                end
`ifdef SPI_RESP_WRITE_EN
                DATA_IN: begin
                    if (byte_done) begin
                        spi_wr   = wel;
                        addr_inc = 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // Byte fetched into the output shift register: status in RDSR, otherwise
    // memory with a same-cycle preload forwarded (write-first).
    always_comb begin
        fetch_byte = mem[addr_q[AW-1:0]];
        if (state == STATUS_OUT)
            fetch_byte = status_byte;
        else if (load_en && (load_addr == addr_q[AW-1:0]))
            fetch_byte = load_data;
    end

    // Receive/transmit shifters, counters, address and pin outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_shift  <= '0;
            bit_cnt   <= '0;
            tx_cnt    <= '0;
            tx_shift  <= '0;
            addr_hi   <= '0;
            addr_q    <= '0;
            fetch_req <= 1'b0;
            miso      <= 1'b0;
            miso_oe   <= 1'b0;
        end else begin
            fetch_req <= fetch_set;

            if (start || deselect) begin
                bit_cnt <= '0;
                tx_cnt  <= '0;
            end else begin
                if (sclk_rise && state != IDLE) begin
                    rx_shift <= rx_byte[6:0];
                    bit_cnt  <= bit_cnt + 3'd1;
                end
                if (shift_out) tx_cnt <= tx_cnt + 3'd1;
            end

            if (hi_ld) addr_hi <= rx_byte;

            if (addr_ld)       addr_q <= {addr_hi, rx_byte} & ADDR_MASK;
            else if (addr_inc) addr_q <= (addr_q + 16'd1) & ADDR_MASK;

            if (fetch_req)      tx_shift <= fetch_byte;
            else if (shift_out) tx_shift <= {tx_shift[6:0], 1'b0};

            if (deselect) begin
                miso    <= 1'b0;
                miso_oe <= 1'b0;
            end else if (shift_out) begin
                miso    <= tx_shift[7];
                miso_oe <= 1'b1;
            end
        end
    end

    // Byte storage; preload has priority over an SPI write to the same byte.
    // NOTE: the memory array has no reset, so it maps onto RAM and preloaded
    // contents survive a reset of the control logic.
    always_ff @(posedge clk) begin
`ifdef SPI_RESP_WRITE_EN
        if (reset && spi_wr) mem[addr_q[AW-1:0]] <= rx_byte;
`endif
        if (load_en) mem[load_addr] <= load_data;
    end

`ifdef SPI_RESP_WRITE_EN
    // Write-enable latch: WREN arms it at deselect, WRDI clears it at once,
    // and any WRITE transaction drops it at deselect.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wel        <= 1'b0;
            wren_pend  <= 1'b0;
            write_seen <= 1'b0;
        end else if (start) begin
            wren_pend  <= 1'b0;
            write_seen <= 1'b0;
        end else if (deselect) begin
            if (write_seen)     wel <= 1'b0;
            else if (wren_pend) wel <= 1'b1;
            wren_pend  <= 1'b0;
            write_seen <= 1'b0;
        end else begin
            if (wren_set)  wren_pend  <= 1'b1;
            if (wel_clr)   wel        <= 1'b0;
            if (write_cmd) write_seen <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_spi_eeprom_responder.sv
// Directed testbench for spi_eeprom_responder: acts as an SPI mode-0 master
// with spi_clk = clk/8 and compares received bytes and pin states against
// hand-computed values. Covers SPI_RESP_WRITE_EN when that macro is defined.
module tb_spi_eeprom_responder;

    localparam int DEPTH         = 1024;
    localparam int CLK_RATIO_MIN = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       spi_clk;
    logic       mosi;
    logic       spi_en;
    logic       miso;
    logic       miso_oe;
    logic       load_en;
    logic [9:0] load_addr;
    logic [7:0] load_data;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    int spi_half = 4;

    // Pin activity seen by the master since the last clear_seen().
    logic oe_seen_hi, oe_seen_lo, miso_seen;

    spi_eeprom_responder #(
        .DEPTH(DEPTH), .SYNC_STAGES(2), .CLK_RATIO_MIN(CLK_RATIO_MIN)
    ) dut (
        .clk(clk), .reset(reset), .spi_clk(spi_clk), .mosi(mosi), .spi_en(spi_en),
        .miso(miso), .miso_oe(miso_oe), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_seen();
        oe_seen_hi = 1'b0;
        oe_seen_lo = 1'b0;
        miso_seen  = 1'b0;
    endtask

    // One SPI bit: low phase with mosi set, master samples miso at the rising
    // edge, high phase, then the falling edge that shifts the slave.
    task automatic spi_bit(input logic b, output logic r);
        mosi = b;
        repeat (spi_half) @(negedge clk);
        r = miso;
        if (miso_oe) oe_seen_hi = 1'b1; else oe_seen_lo = 1'b1;
        if (miso) miso_seen = 1'b1;
        spi_clk = 1'b1;
        repeat (spi_half) @(negedge clk);
        spi_clk = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], b);
            rx[i] = b;
        end
    endtask

    task automatic select();
        spi_en = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic deselect();
        repeat (2) @(negedge clk);
        spi_en = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic preload(input logic [9:0] a, input logic [7:0] d);
        @(negedge clk);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        @(negedge clk);
        load_en   = 1'b0;
    endtask

    task automatic read_start(input logic [15:0] a);
        logic [7:0] d;
        select();
        spi_byte(8'h03, d);
        spi_byte(a[15:8], d);
        spi_byte(a[7:0], d);
    endtask

    task automatic read_status(input string tag, input logic [7:0] exp);
        logic [7:0] d;
        select();
        spi_byte(8'h05, d);
        spi_byte(8'h00, d);
        check(tag, d, exp);
        deselect();
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] burst_exp [4];
        burst_exp[0] = 8'h11; burst_exp[1] = 8'h22;
        burst_exp[2] = 8'h33; burst_exp[3] = 8'h44;

        reset = 1'b0; spi_en = 1'b1; spi_clk = 1'b0; mosi = 1'b0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        clear_seen();

        if (2 * spi_half < CLK_RATIO_MIN) begin
            $display("FAIL clk_ratio: spi half period %0d below minimum", spi_half);
            $fatal(1, "clk ratio");
        end

        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        preload(10'h000, 8'h11); preload(10'h001, 8'h22);
        preload(10'h002, 8'h33); preload(10'h003, 8'h44);
        preload(10'h010, 8'h66); preload(10'h011, 8'h77);
        preload(10'h020, 8'hC1); preload(10'h021, 8'hC2);

        // Reset held for 3 clk while spi_en toggles.
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            spi_en = ~spi_en;
            @(negedge clk);
            check("reset_miso", miso, 1'b0);
            check("reset_oe", miso_oe, 1'b0);
            check("reset_busy", busy, 1'b0);
        end
        spi_en = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Burst read of four bytes from 0x0000.
        clear_seen();
        read_start(16'h0000);
        check("addr_phase_oe", oe_seen_hi, 1'b0);
        check("busy_selected", busy, 1'b1);
        clear_seen();
        for (int k = 0; k < 4; k++) begin
            spi_byte(8'h00, d);
            check($sformatf("burst_byte%0d", k), d, burst_exp[k]);
        end
        check("data_phase_oe_gap", oe_seen_lo, 1'b0);
        deselect();
        check("deselect_oe", miso_oe, 1'b0);
        check("deselect_miso", miso, 1'b0);
        check("deselect_busy", busy, 1'b0);

        // Address wrap and modulo addressing.
        preload(10'h3FF, 8'hAA);
        preload(10'h000, 8'h55);
        read_start(16'h03FF);
        spi_byte(8'h00, d); check("wrap_last", d, 8'hAA);
        spi_byte(8'h00, d); check("wrap_first", d, 8'h55);
        deselect();
        read_start(16'h0403);
        spi_byte(8'h00, d); check("addr_modulo", d, 8'h44);
        deselect();

        // Status read streams 00 twice.
        select();
        spi_byte(8'h05, d);
        spi_byte(8'h00, d); check("rdsr_byte0", d, 8'h00);
        spi_byte(8'h00, d); check("rdsr_byte1", d, 8'h00);
        deselect();

        // Unknown command: pins stay quiet for 24 clocks.
        select();
        clear_seen();
        spi_byte(8'h9F, d);
        for (int k = 0; k < 3; k++) spi_byte(8'hFF, d);
        check("unknown_oe", oe_seen_hi, 1'b0);
        check("unknown_miso", miso_seen, 1'b0);
        deselect();

        // Abort after 5 address bits, then a clean read.
        select();
        spi_byte(8'h03, d);
        for (int k = 0; k < 5; k++) spi_bit(1'b1, d[0]);
        deselect();
        read_start(16'h0002);
        spi_byte(8'h00, d); check("after_abort", d, 8'h33);
        deselect();

        // Preload during DATA_OUT reaches the next prefetched byte.
        read_start(16'h0020);
        for (int i = 7; i >= 4; i--) spi_bit(1'b0, d[i]);
        preload(10'h021, 8'hD7);
        for (int i = 3; i >= 0; i--) spi_bit(1'b0, d[i]);
        check("load_mid_byte0", d, 8'hC1);
        spi_byte(8'h00, d); check("load_mid_byte1", d, 8'hD7);
        deselect();

        // Reset in the middle of DATA_OUT.
        read_start(16'h0000);
        for (int k = 0; k < 3; k++) spi_bit(1'b0, d[0]);
        check("oe_before_reset", miso_oe, 1'b1);
        reset = 1'b0;
        @(negedge clk);
        check("midreset_oe", miso_oe, 1'b0);
        check("midreset_miso", miso, 1'b0);
        reset = 1'b1;
        clear_seen();
        spi_byte(8'h00, d);
        check("no_resume_after_reset", oe_seen_hi, 1'b0);
        deselect();
        read_start(16'h0001);
        spi_byte(8'h00, d); check("recover_read", d, 8'h22);
        deselect();

`ifdef SPI_RESP_WRITE_EN
        select(); spi_byte(8'h06, d); deselect();
        read_status("wren_status", 8'h02);
        select();
        spi_byte(8'h02, d); spi_byte(8'h00, d); spi_byte(8'h10, d); spi_byte(8'hA5, d);
        deselect();
        read_start(16'h0010);
        spi_byte(8'h00, d); check("write_readback", d, 8'hA5);
        deselect();
        read_status("wel_cleared", 8'h00);
        select();
        spi_byte(8'h02, d); spi_byte(8'h00, d); spi_byte(8'h11, d); spi_byte(8'h5A, d);
        deselect();
        read_start(16'h0011);
        spi_byte(8'h00, d); check("write_no_wren", d, 8'h77);
        deselect();
`else
        select();
        clear_seen();
        spi_byte(8'h06, d);
        spi_byte(8'h00, d);
        check("wren_ignored_oe", oe_seen_hi, 1'b0);
        deselect();
        read_status("wel_const_zero", 8'h00);
        select();
        spi_byte(8'h02, d); spi_byte(8'h00, d); spi_byte(8'h10, d); spi_byte(8'hA5, d);
        deselect();
        read_start(16'h0010);
        spi_byte(8'h00, d); check("write_ignored", d, 8'h66);
        deselect();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
